// File: rtl/fullchip_pkg.sv
// Shared definitions for the fullchip instruction sequencer.
//  - seq_state_e : sequencer phase encoding
//  - INST_*      : bit positions inside the 17-bit fullchip inst word
//  - phase_last  : terminal count (length - 1) of each phase
package fullchip_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_QWR,
    S_KWR,
    S_GAP,
    S_LOAD,
    S_EXEC,
    S_OFIFO,
    S_ACC,
    S_FDRAIN,
    S_DIV,
    S_DONE
  } seq_state_e;

  localparam int INST_W         = 17;
  localparam int INST_OFIFO_RD  = 16;
  localparam int INST_QK_ADD_HI = 15;
  localparam int INST_QK_ADD_LO = 12;
  localparam int INST_P_ADD_HI  = 11;
  localparam int INST_P_ADD_LO  = 8;
  localparam int INST_EXEC      = 7;
  localparam int INST_LOAD      = 6;
  localparam int INST_QMEM_RD   = 5;
  localparam int INST_QMEM_WR   = 4;
  localparam int INST_KMEM_RD   = 3;
  localparam int INST_KMEM_WR   = 2;
  localparam int INST_PMEM_RD   = 1;
  localparam int INST_PMEM_WR   = 0;

  localparam int CNT_W = 8;

  // Last counter value of a phase. For QWR/KWR the counter advances on
  // accepted beats only, so this is the index of the final beat.
  function automatic logic [CNT_W-1:0] phase_last(input seq_state_e s,
                                                  input int n_col,
                                                  input int n_q,
                                                  input int n_gap);
    int len;
    len = 1;
    case (s)
      S_QWR:            len = n_q;
      S_KWR:            len = n_col;
      S_GAP:            len = n_gap;
      S_LOAD:           len = n_col + 2;
      S_EXEC, S_OFIFO:  len = n_q;
      S_ACC, S_DIV:     len = n_q + 1;
      S_FDRAIN:         len = n_q + 2;
      default:          len = 1;
    endcase
    return CNT_W'(len - 1);
  endfunction

endpackage

// File: rtl/seq_phase_cnt.sv
// Phase cycle counter for the instruction sequencer.
//  clk, reset (sync, active-low)
//  clr  : zero the count (phase entry), wins over en
//  en   : advance by one
//  last : terminal value of the current phase
//  cnt  : current count
//  tc   : cnt == last
module seq_phase_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == last);

endmodule

// File: rtl/fullchip_inst_seq.sv
// Hardware initiator for the fullchip inst bus. Accepts total_cycle Q vectors
// then col K vectors over a valid/ready stream and plays one attention pass:
// Qmem wr, Kmem wr, K load, execute, ofifo->pmem, pmem->sfp acc, sum-fifo
// drain, div.
//  clk, reset   : single clock, synchronous active-low reset
//  start        : pulse in IDLE begins a pass
//  in_data/in_valid/in_ready : Q/K vector stream (in_ready comb from state)
//  inst         : {ofifo_rd,qkmem_add,pmem_add,execute,load,qmem_rd,qmem_wr,
//                  kmem_rd,kmem_wr,pmem_rd,pmem_wr}
//  mem_in       : registered data of the last accepted beat
//  acc/div/fifo_ext_rd : sfp and sum fifo controls
//  busy         : high outside IDLE; done : one-cycle pulse leaving DONE
module fullchip_inst_seq
  import fullchip_pkg::*;
#(
  parameter int bw          = 8,
  parameter int pr          = 16,
  parameter int col         = 8,
  parameter int total_cycle = 8,
  parameter int gap         = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [pr*bw-1:0]    in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [INST_W-1:0]   inst,
  output logic [pr*bw-1:0]    mem_in,
  output logic                acc,
  output logic                div,
  output logic                fifo_ext_rd,
  output logic                busy,
  output logic                done
);

  localparam logic [CNT_W-1:0] COL_C = CNT_W'(col);

  seq_state_e        state_q, state_d;
  seq_state_e        ret_q, ret_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [pr*bw-1:0]  mem_in_q, mem_in_d;
  logic              acc_q, acc_d;
  logic              div_q, div_d;
  logic              fifo_ext_rd_q, fifo_ext_rd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_last;
  logic              cnt_tc;
  logic              cnt_en;
  logic              cnt_clr;
  logic              beat;
  logic [3:0]        qk_add;
  logic [3:0]        p_add;
  logic [3:0]        hold_add;

  assign in_ready = (state_q == S_QWR) || (state_q == S_KWR);
  assign beat     = in_valid & in_ready;
  assign cnt_last = phase_last(state_q, col, total_cycle, gap);
  assign cnt_clr  = (state_d != state_q);

  // While stalled in QWR/KWR the address stays on the last written slot,
  // which is 0 before the first beat of the phase.
  assign hold_add = (cnt == '0) ? 4'd0 : 4'(cnt - CNT_W'(1));

  seq_phase_cnt #(
    .W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .last  (cnt_last),
    .cnt   (cnt),
    .tc    (cnt_tc)
  );

  always_comb begin
    state_d       = state_q;
    ret_d         = ret_q;
    cnt_en        = 1'b1;
    inst_d        = '0;
    mem_in_d      = mem_in_q;
    acc_d         = 1'b0;
    div_d         = 1'b0;
    fifo_ext_rd_d = 1'b0;
    done_d        = 1'b0;
    qk_add        = 4'd0;
    p_add         = 4'd0;

    case (state_q)
      S_IDLE: begin
        cnt_en = 1'b0;
        if (start) begin
          state_d = S_QWR;
        end
      end

      S_QWR: begin
        cnt_en = beat;
        qk_add = hold_add;
        if (beat) begin
          inst_d[INST_QMEM_WR] = 1'b1;
          qk_add               = cnt[3:0];
          mem_in_d             = in_data;
          if (cnt_tc) begin
            state_d = S_KWR;
          end
        end
      end

      S_KWR: begin
        cnt_en = beat;
        qk_add = hold_add;
        if (beat) begin
          inst_d[INST_KMEM_WR] = 1'b1;
          qk_add               = cnt[3:0];
          mem_in_d             = in_data;
          if (cnt_tc) begin
            state_d = S_GAP;
            ret_d   = S_LOAD;
          end
        end
      end

      S_GAP: begin
        if (cnt_tc) begin
          state_d = ret_q;
        end
      end

      // load spans col+2 cycles; kmem reads run on cycles 1..col and the
      // address lags the cycle count by two, parking at 0 on the final cycle.
      S_LOAD: begin
        inst_d[INST_LOAD]    = 1'b1;
        inst_d[INST_KMEM_RD] = (cnt >= CNT_W'(1)) && (cnt <= COL_C);
        if ((cnt >= CNT_W'(2)) && (cnt <= COL_C)) begin
          qk_add = 4'(cnt - CNT_W'(2));
        end
        if (cnt_tc) begin
          state_d = S_GAP;
          ret_d   = S_EXEC;
        end
      end

      S_EXEC: begin
        inst_d[INST_EXEC]    = 1'b1;
        inst_d[INST_QMEM_RD] = 1'b1;
        qk_add               = cnt[3:0];
        if (cnt_tc) begin
          state_d = S_GAP;
          ret_d   = S_OFIFO;
        end
      end

      S_OFIFO: begin
        inst_d[INST_OFIFO_RD] = 1'b1;
        inst_d[INST_PMEM_WR]  = 1'b1;
        p_add                 = cnt[3:0];
        if (cnt_tc) begin
          state_d = S_GAP;
          ret_d   = S_ACC;
        end
      end

      // ACC and DIV run one cycle past total_cycle; the address wraps mod 16.
      S_ACC: begin
        acc_d                = 1'b1;
        inst_d[INST_PMEM_RD] = 1'b1;
        p_add                = cnt[3:0];
        if (cnt_tc) begin
          state_d = S_FDRAIN;
        end
      end

      S_FDRAIN: begin
        fifo_ext_rd_d = 1'b1;
        if (cnt_tc) begin
          state_d = S_DIV;
        end
      end

      S_DIV: begin
        div_d                = 1'b1;
        inst_d[INST_PMEM_RD] = 1'b1;
        p_add                = cnt[3:0];
        if (cnt_tc) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    inst_d[INST_QK_ADD_HI:INST_QK_ADD_LO] = qk_add;
    inst_d[INST_P_ADD_HI:INST_P_ADD_LO]   = p_add;
    // busy follows the state being entered so it is high for every non-IDLE
    // cycle, not one cycle late.
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      ret_q         <= S_IDLE;
      inst_q        <= '0;
      mem_in_q      <= '0;
      acc_q         <= 1'b0;
      div_q         <= 1'b0;
      fifo_ext_rd_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ret_q         <= ret_d;
      inst_q        <= inst_d;
      mem_in_q      <= mem_in_d;
      acc_q         <= acc_d;
      div_q         <= div_d;
      fifo_ext_rd_q <= fifo_ext_rd_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign inst        = inst_q;
  assign mem_in      = mem_in_q;
  assign acc         = acc_q;
  assign div         = div_q;
  assign fifo_ext_rd = fifo_ext_rd_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_fullchip_inst_seq.sv
// Scoreboard bench for fullchip_inst_seq: the driver issues one input set per
// cycle and pushes the expected outputs after the next clock edge; a monitor
// pops and compares one record per cycle.
module tb_fullchip_inst_seq;

  localparam int BW  = 8;
  localparam int PR  = 16;
  localparam int COL = 8;
  localparam int TC  = 8;
  localparam int GAP = 10;
  localparam int DW  = PR * BW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [16:0]   inst;
  logic [DW-1:0] mem_in;
  logic          acc;
  logic          div;
  logic          fifo_ext_rd;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  fullchip_inst_seq #(
    .bw          (BW),
    .pr          (PR),
    .col         (COL),
    .total_cycle (TC),
    .gap         (GAP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .inst        (inst),
    .mem_in      (mem_in),
    .acc         (acc),
    .div         (div),
    .fifo_ext_rd (fifo_ext_rd),
    .busy        (busy),
    .done        (done)
  );

  typedef struct packed {
    logic [16:0]   inst;
    logic [DW-1:0] mem;
    logic          acc;
    logic          dv;
    logic          fe;
    logic          busy;
    logic          done;
    logic          rdy;
  } rec_t;

  rec_t          exp_q[$];
  rec_t          tail_q[$];
  int            n_chk  = 0;
  int            n_fail = 0;
  int            mode   = 0;   // 0 idle, 1 accepting vectors, 2 playing phases
  int            beats  = 0;
  logic [DW-1:0] last_mem = '0;

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [16:0] mk_inst(int ofrd, int qa, int pa, int ex, int ld,
                                          int qrd, int qwr, int krd, int kwr,
                                          int prd, int pwr);
    logic [16:0] i;
    i        = '0;
    i[16]    = (ofrd != 0);
    i[15:12] = 4'(qa);
    i[11:8]  = 4'(pa);
    i[7]     = (ex != 0);
    i[6]     = (ld != 0);
    i[5]     = (qrd != 0);
    i[4]     = (qwr != 0);
    i[3]     = (krd != 0);
    i[2]     = (kwr != 0);
    i[1]     = (prd != 0);
    i[0]     = (pwr != 0);
    return i;
  endfunction

  function automatic rec_t base_rec();
    rec_t r;
    r      = '0;
    r.mem  = last_mem;
    r.busy = 1'b1;
    return r;
  endfunction

  task automatic push_gap();
    for (int c = 0; c < GAP; c++) tail_q.push_back(base_rec());
  endtask

  // Output trace of everything after the last K beat, phase by phase.
  task automatic build_tail();
    rec_t r;
    push_gap();
    for (int c = 0; c < COL + 2; c++) begin
      r = base_rec();
      r.inst = mk_inst(0, (c >= 2 && c <= COL) ? c - 2 : 0, 0, 0, 1, 0, 0,
                       (c >= 1 && c <= COL) ? 1 : 0, 0, 0, 0);
      tail_q.push_back(r);
    end
    push_gap();
    for (int c = 0; c < TC; c++) begin
      r = base_rec();
      r.inst = mk_inst(0, c, 0, 1, 0, 1, 0, 0, 0, 0, 0);
      tail_q.push_back(r);
    end
    push_gap();
    for (int c = 0; c < TC; c++) begin
      r = base_rec();
      r.inst = mk_inst(1, 0, c, 0, 0, 0, 0, 0, 0, 0, 1);
      tail_q.push_back(r);
    end
    push_gap();
    for (int c = 0; c <= TC; c++) begin
      r = base_rec();
      r.acc  = 1'b1;
      r.inst = mk_inst(0, 0, c % 16, 0, 0, 0, 0, 0, 0, 1, 0);
      tail_q.push_back(r);
    end
    for (int c = 0; c < TC + 2; c++) begin
      r = base_rec();
      r.fe = 1'b1;
      tail_q.push_back(r);
    end
    for (int c = 0; c <= TC; c++) begin
      r = base_rec();
      r.dv   = 1'b1;
      r.inst = mk_inst(0, 0, c % 16, 0, 0, 0, 0, 0, 0, 1, 0);
      tail_q.push_back(r);
    end
    r = base_rec();
    r.busy = 1'b0;
    r.done = 1'b1;
    tail_q.push_back(r);
  endtask

  // Drive one cycle of inputs and record what the outputs must be after the
  // clock edge that samples them.
  task automatic step(input logic rst_n, input logic st, input logic v,
                      input logic [DW-1:0] d);
    rec_t e;
    int   idx;
    @(negedge clk);
    reset    = rst_n;
    start    = st;
    in_valid = v;
    in_data  = d;
    e     = '0;
    e.mem = last_mem;
    if (!rst_n) begin
      mode     = 0;
      beats    = 0;
      last_mem = '0;
      e.mem    = '0;
      tail_q.delete();
    end else if (mode == 0) begin
      if (st) begin
        mode   = 1;
        beats  = 0;
        e.busy = 1'b1;
        e.rdy  = 1'b1;
      end
    end else if (mode == 1) begin
      e.busy = 1'b1;
      e.rdy  = 1'b1;
      if (v) begin
        if (beats < TC) e.inst = mk_inst(0, beats, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        else            e.inst = mk_inst(0, beats - TC, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        e.mem    = d;
        last_mem = d;
        beats++;
        if (beats == TC + COL) begin
          mode  = 2;
          e.rdy = 1'b0;
          build_tail();
        end
      end else begin
        if (beats < TC) idx = (beats == 0) ? 0 : beats - 1;
        else            idx = (beats == TC) ? 0 : beats - TC - 1;
        e.inst = mk_inst(0, idx, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      end
    end else begin
      e = tail_q.pop_front();
      if (tail_q.size() == 0) mode = 0;
    end
    exp_q.push_back(e);
  endtask

  task automatic do_write(input bit rand_valid);
    int   guard;
    logic v;
    guard = 0;
    while (mode == 1) begin
      v = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      if (guard > 60) v = 1'b1;
      guard++;
      step(1'b1, 1'b0, v, rnd_data());
    end
  endtask

  // start and in_valid are thrown at the sequencer while it plays the pass.
  task automatic do_play();
    while (mode == 2) begin
      step(1'b1, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), rnd_data());
    end
  endtask

  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, got, want);
    end
  endtask

  // Monitor: one record per cycle, sampled 1 time unit after the edge.
  initial begin
    rec_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("inst",        DW'(inst),        DW'(e.inst));
        chk("mem_in",      mem_in,           e.mem);
        chk("acc",         DW'(acc),         DW'(e.acc));
        chk("div",         DW'(div),         DW'(e.dv));
        chk("fifo_ext_rd", DW'(fifo_ext_rd), DW'(e.fe));
        chk("busy",        DW'(busy),        DW'(e.busy));
        chk("done",        DW'(done),        DW'(e.done));
        chk("in_ready",    DW'(in_ready),    DW'(e.rdy));
      end
    end
  end

  initial begin
    #200000;
    n_chk++;
    n_fail++;
    $display("FAIL timeout t=%0t got=running expected=finished", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;

    // reset, then idle with stray in_valid
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, rnd_data());
    repeat (3) step(1'b1, 1'b0, 1'($urandom_range(0, 1)), rnd_data());

    // pass with in_valid held high, starts thrown in while busy
    step(1'b1, 1'b1, 1'b0, '0);
    do_write(1'b0);
    do_play();
    repeat (3) step(1'b1, 1'b0, 1'b1, rnd_data());

    // pass with explicit 1,0,1 stall pattern then random valid
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, rnd_data());
    step(1'b1, 1'b0, 1'b0, rnd_data());
    step(1'b1, 1'b0, 1'b1, rnd_data());
    do_write(1'b1);
    do_play();
    repeat (2) step(1'b1, 1'b0, 1'b0, '0);

    // pass aborted by a one-cycle reset in the middle of EXEC
    step(1'b1, 1'b1, 1'b0, '0);
    do_write(1'b0);
    repeat (GAP + COL + 2 + GAP + 3) step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    repeat (4) step(1'b1, 1'b0, 1'b0, '0);

    // recovery pass with random valid
    step(1'b1, 1'b1, 1'b0, '0);
    do_write(1'b1);
    do_play();
    repeat (3) step(1'b1, 1'b0, 1'b0, '0);

    @(posedge clk);
    #2;
    chk("scoreboard_drained", DW'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
